mem_port_arbiter: RTL

- Shares the single unified memory port between instruction fetch and the load/store path of the core.
- Data accesses carry the 3-bit AddrMode produced by the control unit. Values 000–100 are loads LB/LH/LW/LBU/LHU; 101–111 are stores SB/SH/SW.
- Data accesses have priority over fetch. A fairness counter bounds how long fetch can be starved.
- Drives a stall signal back to the pipeline while any requester is waiting.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter: AddrMode encoding,
// arbiter FSM states and the fixed mode used for instruction fetch.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b011,
    LHU = 3'b100,
    SB  = 3'b101,
    SH  = 3'b110,
    SW  = 3'b111
  } addr_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY_IF = 2'b01,
    BUSY_D  = 2'b10
  } arb_state_t;

  // Instruction fetch is always a full-word load.
  localparam addr_mode_t FETCH_MODE = LW;

  // Stores occupy the top of the AddrMode encoding (SB..SW).
  function automatic logic is_store(input addr_mode_t mode);
    return (mode >= SB);
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the
// load/store path. Optional busy timeout is enabled with ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_WAIT    = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [2:0]            d_mode,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_mode,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  stall,
  output logic                  err
);

  if (MAX_WAIT < 1 || MAX_WAIT > 15 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("mem_port_arbiter: MAX_WAIT must be 1..15 and TIMEOUT_CYC >= 2");
  end

  arb_state_t            state_q, state_d;
  logic                  issue_q;
  logic [3:0]            wait_cnt_q;
  logic [DATA_WIDTH-1:0] cmd_addr_q;
  addr_mode_t            cmd_mode_q;
  logic [DATA_WIDTH-1:0] cmd_wdata_q;
  logic                  cmd_we_q;

  logic grant_d, grant_if;
  logic timeout_hit, timeout_fire;
  logic fetch_due;

  assign fetch_due = (wait_cnt_q == 4'(MAX_WAIT));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    grant_d      = 1'b0;
    grant_if     = 1'b0;
    timeout_fire = 1'b0;
    if_rvalid    = 1'b0;
    d_rvalid     = 1'b0;
    if_rdata     = '0;
    d_rdata      = '0;

    case (state_q)
      IDLE: begin
        grant_d  = d_req && !(if_req && fetch_due);
        grant_if = if_req && !grant_d;
        if (grant_d)       state_d = BUSY_D;
        else if (grant_if) state_d = BUSY_IF;
      end

      BUSY_IF, BUSY_D: begin
        // A real response in the deadline cycle takes precedence over the abort.
        timeout_fire = timeout_hit && !mem_rvalid;
        if (mem_rvalid || timeout_fire) begin
          state_d = IDLE;
          if (state_q == BUSY_IF) begin
            if_rvalid = 1'b1;
            if (mem_rvalid) if_rdata = mem_rdata;
          end else begin
            d_rvalid = 1'b1;
            if (mem_rvalid && !cmd_we_q) d_rdata = mem_rdata;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the command registers are reset along with the control state, so the
  // memory-side outputs read 0 after reset instead of stale fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      issue_q     <= 1'b0;
      wait_cnt_q  <= '0;
      cmd_addr_q  <= '0;
      cmd_mode_q  <= LB;
      cmd_wdata_q <= '0;
      cmd_we_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      issue_q <= grant_d || grant_if;

      if (grant_d) begin
        cmd_addr_q  <= d_addr;
        cmd_mode_q  <= addr_mode_t'(d_mode);
        cmd_wdata_q <= d_wdata;
        cmd_we_q    <= is_store(addr_mode_t'(d_mode));
      end else if (grant_if) begin
        cmd_addr_q  <= if_addr;
        cmd_mode_q  <= FETCH_MODE;
        cmd_wdata_q <= '0;
        cmd_we_q    <= 1'b0;
      end

      // Fairness only counts contested rounds that fetch lost.
      if (grant_if) begin
        wait_cnt_q <= '0;
      end else if (grant_d && if_req && !fetch_due) begin
        wait_cnt_q <= wait_cnt_q + 4'd1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYC);

  logic [TCNT_W-1:0] tcnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
    end else if (grant_d || grant_if) begin
      tcnt_q <= '0;
    end else if (state_q != IDLE && !mem_rvalid) begin
      tcnt_q <= tcnt_q + TCNT_W'(1);
    end
  end

  assign timeout_hit = (state_q != IDLE) && (tcnt_q == TCNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign err       = timeout_fire;
  assign mem_en    = issue_q;
  assign if_gnt    = issue_q && (state_q == BUSY_IF);
  assign d_gnt     = issue_q && (state_q == BUSY_D);
  assign mem_we    = cmd_we_q;
  assign mem_addr  = cmd_addr_q;
  assign mem_mode  = cmd_mode_q;
  assign mem_wdata = cmd_wdata_q;
  assign stall     = (d_req && !d_rvalid) || (if_req && !if_rvalid);

endmodule
